usr_param_burst: RTL and testbench

- Parametrised universal shift register for the Registers family. WIDTH bits, with hold, shift right, shift left and parallel load selected by a 2-bit select.
- Adds a per-operation rotate mode and a counted burst-shift engine: one start pulse performs amt single-bit shifts on consecutive cycles, with busy/done status.
- Used as a configurable SISO/SIPO/PISO/PIPO building block and as a multi-position shifter beside wider datapaths.

---
 rtl/usr_pkg.sv | 18 +
 rtl/usr_shift_core.sv | 34 +++
 rtl/usr_param_burst.sv | 108 ++++++++++
 tb/tb_usr_param_burst.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register with burst engine:
// select codes, FSM state type and burst direction constants.
package usr_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage : usr_pkg

// File: rtl/usr_shift_core.sv
// Combinational next-q datapath: hold, shift right/left (serial or circular)
// and parallel load. Shared by the direct select path and the burst engine.
module usr_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       op,
    input  logic             rot,
    input  logic             data_in_sr,
    input  logic             data_in_sl,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] q_next
);

    logic in_r;
    logic in_l;

    // In circular mode the bit falling off one end re-enters at the other.
    assign in_r = rot ? q[0]       : data_in_sr;
    assign in_l = rot ? q[WIDTH-1] : data_in_sl;

    always_comb begin
        q_next = q;
        unique case (op)
            SEL_SHR:  q_next = {in_r, q[WIDTH-1:1]};
            SEL_SHL:  q_next = {q[WIDTH-2:0], in_l};
            SEL_LOAD: q_next = D;
            default:  q_next = q;
        endcase
    end

endmodule : usr_shift_core

// File: rtl/usr_param_burst.sv
// Universal shift register with a counted burst-shift engine: a start pulse
// performs amt single-bit shifts on consecutive edges with busy/done status.
module usr_param_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] D,
    input  logic             data_in_sr,
    input  logic             data_in_sl,
    input  logic             rot,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             sr_out,
    output logic             sl_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       op;

    usr_shift_core #(.WIDTH(WIDTH)) u_core (
        .q          (q_q),
        .op         (op),
        .rot        (rot),
        .data_in_sr (data_in_sr),
        .data_in_sl (data_in_sl),
        .D          (D),
        .q_next     (q_d)
    );

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op      = sel;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // The accepting edge holds q; shifting begins on the next edge.
                    op = SEL_HOLD;
                    if (amt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = amt;
                        dir_d   = dir;
                        busy_d  = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                op    = (dir_q == DIR_LEFT) ? SEL_SHL : SEL_SHR;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
        end
    end

    assign q      = q_q;
    assign sr_out = q_q[0];
    assign sl_out = q_q[WIDTH-1];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : usr_param_burst

// File: tb/tb_usr_param_burst.sv
// Scoreboard bench for usr_param_burst: stimulus pushes model predictions,
// a monitor pops and compares them after every clock edge.
module tb_usr_param_burst;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       sel;
    logic [WIDTH-1:0] D;
    logic             data_in_sr, data_in_sl, rot, start, dir;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic             sr_out, sl_out, busy, done;

    usr_param_burst #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .D          (D),
        .data_in_sr (data_in_sr),
        .data_in_sl (data_in_sl),
        .rot        (rot),
        .start      (start),
        .amt        (amt),
        .dir        (dir),
        .q          (q),
        .sr_out     (sr_out),
        .sl_out     (sl_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        string            tag;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register value plus "shifts still owed" for a burst.
    logic [WIDTH-1:0] m_q;
    int               m_left;
    logic             m_dir;
    logic             m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] shift_val(input logic [WIDTH-1:0] v, input logic left,
                                                   input logic r, input logic sr_in, input logic sl_in);
        logic [WIDTH-1:0] top_bit;
        if (!left) begin
            top_bit = r ? WIDTH'(v % 2) : WIDTH'(sr_in);
            return (v / 2) + (top_bit << (WIDTH - 1));
        end
        return WIDTH'(v * 2) + (r ? WIDTH'(v >> (WIDTH - 1)) : WIDTH'(sl_in));
    endfunction

    task automatic model_reset();
        m_q    = '0;
        m_left = 0;
        m_dir  = 1'b0;
        m_done = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of inputs on the falling edge and predict the post-edge state.
    task automatic step(input string tag, input logic [1:0] s, input logic [WIDTH-1:0] d,
                        input logic i_sr, input logic i_sl, input logic i_rot,
                        input logic i_start, input logic [CNT_W-1:0] i_amt, input logic i_dir);
        exp_t e;
        @(negedge clk);
        sel = s; D = d; data_in_sr = i_sr; data_in_sl = i_sl;
        rot = i_rot; start = i_start; amt = i_amt; dir = i_dir;
        m_done = 1'b0;
        if (m_left > 0) begin
            m_q = shift_val(m_q, m_dir, i_rot, i_sr, i_sl);
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (i_start) begin
            if (i_amt == 0) m_done = 1'b1;
            else begin
                m_left = int'(i_amt);
                m_dir  = i_dir;
            end
        end else begin
            case (s)
                2'b01:   m_q = shift_val(m_q, 1'b0, i_rot, i_sr, i_sl);
                2'b10:   m_q = shift_val(m_q, 1'b1, i_rot, i_sr, i_sl);
                2'b11:   m_q = d;
                default: m_q = m_q;
            endcase
        end
        e.q = m_q; e.busy = (m_left > 0); e.done = m_done; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic hold(input string tag);
        step(tag, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        step("load", 2'b11, v, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic idle_inputs();
        sel = 2'b00; D = '0; data_in_sr = 1'b0; data_in_sl = 1'b0;
        rot = 1'b0; start = 1'b0; amt = '0; dir = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".q"},      32'(q),      32'(e.q));
            check({e.tag, ".busy"},   32'(busy),   32'(e.busy));
            check({e.tag, ".done"},   32'(done),   32'(e.done));
            check({e.tag, ".sr_out"}, 32'(sr_out), 32'(e.q[0]));
            check({e.tag, ".sl_out"}, 32'(sl_out), 32'(e.q[WIDTH-1]));
        end
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.q",    32'(q),    32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic operations, serial inputs
        load(8'hA5);
        step("shr_sr1", 2'b01, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step("shl_sl0", 2'b10, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) hold("hold");

        // Rotate ops
        load(8'h81);
        step("rotr", 2'b01, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        load(8'h81);
        step("rotl", 2'b10, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);

        // Burst left with disturbing sel/start while busy
        load(8'h01);
        step("bl_accept", 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(3), 1'b1);
        step("bl_s1", 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(5), 1'b0);
        step("bl_s2", 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step("bl_s3", 2'b01, '0, 1'b1, 1'b0, 1'b0, 1'b1, CNT_W'(2), 1'b0);
        hold("bl_after");

        // Zero-length burst
        load(8'h3C);
        step("amt0", 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        hold("amt0_after");

        // Rotating right bursts of WIDTH and WIDTH+1
        load(8'h3C);
        step("r8_accept", 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(8), 1'b0);
        repeat (8) step("r8", 2'b00, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        hold("r8_after");
        load(8'h3C);
        step("r9_accept", 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(9), 1'b0);
        repeat (9) step("r9", 2'b00, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        hold("r9_after");
        if (m_q !== 8'h1E) check("r9_model", 32'(m_q), 32'h1E);

        // Randomized traffic including back-to-back bursts
        for (int i = 0; i < 400; i++) begin
            step("rand", 2'($urandom_range(0, 3)), WIDTH'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), CNT_W'($urandom_range(0, 15)), 1'($urandom));
        end

        // Asynchronous reset in the middle of a burst
        load(8'h5A);
        step("rst_accept", 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(4), 1'b1);
        step("rst_s1", 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #3;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("midrst.q",    32'(q),    32'h0);
        check("midrst.busy", 32'(busy), 32'h0);
        check("midrst.done", 32'(done), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold("post_rst");
        hold("post_rst");

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_usr_param_burst
